run_control_unit: RTL
=====================

# run_control_unit

Run-control and debug front end for the single-cycle RISC-V core on the DE1-SoC. It replaces the raw push-button core clock with a clock-enable pulse generated from the 50 MHz clock, and adds debounced single-step, timed free-run, full-speed run and run-to-breakpoint modes. It also provides a cycle counter and a parametrised multi-channel hex-display multiplexer. It sits between the board I/O and the core top: the core clocks on `clk` and qualifies every state update with `core_clk_en`.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a synchronised button level must hold before it is accepted (10 ms at 50 MHz).
- SLOW_DIV, 25000000: period in cycles between enables in RUN_SLOW mode (2 Hz).
- NUM_BP, 2: number of PC breakpoint comparators (1..8).
- NUM_CH, 4: number of 32-bit display channels (2..8).
- NUM_DIGITS, 4: number of seven-segment digits driven (4 or 8).

Ports:
- clk  in  1  board clock, 50 MHz
- reset_n  in  1  synchronous, active-low reset
- step_btn_n  in  1  raw push button, active-low, asynchronous to clk
- mode  in  2  00 STEP, 01 RUN_SLOW, 10 RUN_FAST, 11 RUN_TO_BP
- pc_value  in  32  current core PC
- bp_addr  in  32*NUM_BP  breakpoint addresses; entry i is bits [32i+31:32i]
- bp_en  in  NUM_BP  per-breakpoint enable
- ch_data  in  32*NUM_CH  display channels
- ch_sel  in  $clog2(NUM_CH)  selected channel
- win_sel  in  1  nibble window; ignored when NUM_DIGITS=8
- core_clk_en  out  1  one-cycle core advance pulse
- halted  out  1  high in the IDLE and BREAK states
- bp_hit  out  NUM_BP  one-hot indicator of the breakpoint that caused the current BREAK
- cycle_count  out  32  number of core_clk_en pulses issued
- hex_out  out  7*NUM_DIGITS  active-low segments; digit 0 is bits [6:0]

## Operation
- Button path: two-flop synchroniser feeding the debounce counter. The counter reloads on every change of the synchronised level. The debounced level updates when the counter reaches DEBOUNCE_CYCLES-1. A debounced 1→0 transition produces a one-cycle `step_req`.
- FSM states: IDLE, RUN, BREAK.
  - IDLE:
    - mode STEP: `step_req` → `core_clk_en`=1 for one cycle; remain in IDLE.
    - mode ≠ STEP: go to RUN on the next cycle. No pulse is issued in the transition cycle.
  - RUN:
    - RUN_SLOW: pulse when the divider reaches SLOW_DIV-1. The divider then wraps to 0. It is cleared on entering RUN.
    - RUN_FAST: pulse every cycle.
    - RUN_TO_BP: pulse every cycle unless some i has bp_en[i] && bp_addr[i]==pc_value. In that case, suppress the pulse, set bp_hit[i] (lowest i wins on a multiple match), and go to BREAK.
    - Mode changed to STEP: go to IDLE with no pulse in that cycle.
  - BREAK:
    - `step_req` → one pulse, clear bp_hit, return to RUN. The breakpoint check is skipped for that pulse so execution steps past the breakpoint.
    - mode ≠ RUN_TO_BP: clear bp_hit and go to IDLE.
- cycle_count: +1 per pulse; wraps 0xFFFFFFFF→0.
- Display:
  - Word W = ch_data channel ch_sel. An out-of-range ch_sel selects channel 0.
  - Digit k shows nibble (win_sel*NUM_DIGITS + k) of W.
  - Encoding is standard hex, active-low: 0=1000000, 1=1111001, …, F=0001110.
  - hex_out is registered.

## Timing
- Reset (reset_n=0 at a clk edge) leaves the block as follows:
  - FSM in IDLE.
  - core_clk_en=0, halted=1, bp_hit=0, cycle_count=0.
  - Divider and debounce counters cleared; debounced level set to 1 (released).
  - Every hex_out digit = 1000000.
- Reset mid-run aborts any pending pulse at the next edge.
- Button press to pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Held button: exactly one pulse. Release bounce shorter than DEBOUNCE_CYCLES is ignored.
- A `step_req` arriving in RUN is discarded.
- The breakpoint compare uses the pc_value sampled in the same cycle the pulse would issue. The core PC updates on the edge that ends the pulse cycle.
- hex_out follows ch_data/ch_sel/win_sel with 1-cycle latency.
- halted is combinational from state; it rises the cycle after a breakpoint match.

## Test plan
- Reset, then reset_n=1 with DEBOUNCE_CYCLES=4 → halted=1, cycle_count=0, all digits 1000000; after 1 cycle hex_out reflects channel 0.
- STEP mode: one press with 3 cycles of bounce, then held 50 cycles → exactly one core_clk_en, cycle_count=1, asserted 7 cycles after the stable low level.
- RUN_SLOW with SLOW_DIV=5 for 26 cycles after entering RUN → pulses exactly every 5th cycle, cycle_count=5; switching to STEP → halted=1 the next cycle, no further pulses.
- RUN_TO_BP: bp_addr[1]=0x10, bp_en=2'b10, model PC += 4 per pulse from 0 → 4 pulses, then BREAK with bp_hit=2'b10 and cycle_count=4; one press → one pulse with PC 0x10→0x14, then running resumes.
- Both breakpoints set to 0x08 and enabled → bp_hit=2'b01; with bp_en=0 the core runs past 0x08 and does not stop.
- cycle_count preloaded via a 2^32-1 pulse sequence in RUN_FAST (or forced) → wraps to 0; NUM_DIGITS=4, ch_data[2]=0xDEADBEEF, ch_sel=2, win_sel=1 → digits show D,E,A,D (digit 3 = D).

Source files
------------

// File: rtl/run_control_unit.sv
// Run-control front end for the single-cycle core.
//
// Turns a bouncy push button and a mode selector into a one-cycle core clock
// enable. Supports single step, divided free run, full-speed run and
// run-to-breakpoint. Also keeps a count of issued enables and drives a
// multiplexed seven-segment view of one 32-bit display channel.
//
// Ports:
//   clk          50 MHz board clock
//   reset_n      synchronous active-low reset
//   step_btn_n   raw active-low step button (asynchronous)
//   mode         00 step, 01 slow run, 10 fast run, 11 run to breakpoint
//   pc_value     current core PC, compared against the breakpoints
//   bp_addr      NUM_BP packed 32-bit breakpoint addresses
//   bp_en        per-breakpoint enable
//   ch_data      NUM_CH packed 32-bit display channels
//   ch_sel       selected display channel (out of range selects channel 0)
//   win_sel      upper/lower nibble window when only 4 digits are fitted
//   core_clk_en  one-cycle core advance pulse
//   halted       high while idle or stopped at a breakpoint
//   bp_hit       one-hot breakpoint that caused the current stop
//   cycle_count  number of core_clk_en pulses issued (wraps)
//   hex_out      registered active-low segments, digit 0 in bits [6:0]

module run_control_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SLOW_DIV        = 25000000,
    parameter int unsigned NUM_BP          = 2,
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned NUM_DIGITS      = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      step_btn_n,
    input  logic [1:0]                mode,
    input  logic [31:0]               pc_value,
    input  logic [32*NUM_BP-1:0]      bp_addr,
    input  logic [NUM_BP-1:0]         bp_en,
    input  logic [32*NUM_CH-1:0]      ch_data,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel,
    input  logic                      win_sel,
    output logic                      core_clk_en,
    output logic                      halted,
    output logic [NUM_BP-1:0]         bp_hit,
    output logic [31:0]               cycle_count,
    output logic [7*NUM_DIGITS-1:0]   hex_out
);

    localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DivW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [DbW-1:0]  DbMax  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DivW-1:0] DivMax = DivW'(SLOW_DIV - 1);

    localparam logic [1:0] ModeStep = 2'b00;
    localparam logic [1:0] ModeSlow = 2'b01;
    localparam logic [1:0] ModeFast = 2'b10;
    localparam logic [1:0] ModeToBp = 2'b11;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StBreak = 2'd2;

    localparam logic [6:0] SegZero = 7'b1000000;

    logic                    sync1_q, sync2_q;
    logic [DbW-1:0]          db_cnt_q, db_cnt_d;
    logic                    db_level_q, db_level_d;
    logic                    db_last_q;
    logic                    step_req_q, step_req_d;
    logic [1:0]              state_q, state_d;
    logic [DivW-1:0]         div_q, div_d;
    logic [NUM_BP-1:0]       bp_hit_q, bp_hit_d;
    logic [31:0]             cycle_count_q, cycle_count_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    core_en;
    logic [NUM_BP-1:0]       bp_match;
    logic                    bp_any;
    logic [31:0]             disp_word;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Debounce: any return of the synchronised level to the accepted level
    // restarts the count, so only an uninterrupted run is accepted.
    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        if (sync2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbMax) begin
            db_level_d = sync2_q;
            db_cnt_d   = '0;
        end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
        end
        // Accepted press: debounced level fell on the previous edge.
        step_req_d = db_last_q & ~db_level_q;
    end

    // Lowest-index enabled breakpoint matching the current PC.
    always_comb begin
        bp_match = '0;
        bp_any   = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (!bp_any && bp_en[i] && (bp_addr[32*i +: 32] == pc_value)) begin
                bp_match[i] = 1'b1;
                bp_any      = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bp_hit_d = bp_hit_q;
        core_en  = 1'b0;
        case (state_q)
            StIdle: begin
                div_d = '0;
                if (mode == ModeStep) begin
                    core_en = step_req_q;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (mode == ModeStep) begin
                    state_d = StIdle;
                end else if (mode == ModeSlow) begin
                    if (div_q == DivMax) begin
                        core_en = 1'b1;
                        div_d   = '0;
                    end else begin
                        div_d = div_q + DivW'(1);
                    end
                end else if (mode == ModeFast) begin
                    core_en = 1'b1;
                end else if (bp_any) begin
                    bp_hit_d = bp_match;
                    state_d  = StBreak;
                end else begin
                    core_en = 1'b1;
                end
            end
            StBreak: begin
                div_d = '0;
                if (mode != ModeToBp) begin
                    bp_hit_d = '0;
                    state_d  = StIdle;
                end else if (step_req_q) begin
                    // Step past the breakpoint: no compare on this pulse.
                    core_en  = 1'b1;
                    bp_hit_d = '0;
                    state_d  = StRun;
                end
            end
            default: begin
                bp_hit_d = '0;
                state_d  = StIdle;
            end
        endcase
        cycle_count_d = cycle_count_q + {31'b0, core_en};
    end

    always_comb begin : p_hex
        int nib;
        nib       = 0;
        hex_d     = '0;
        disp_word = ch_data[31:0];
        for (int c = 1; c < NUM_CH; c++) begin
            if (32'(ch_sel) == c) begin
                disp_word = ch_data[32*c +: 32];
            end
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib = k;
            if (NUM_DIGITS < 8 && win_sel) begin
                nib = k + int'(NUM_DIGITS);
            end
            hex_d[7*k +: 7] = seg7(disp_word[4*nib +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            db_cnt_q      <= '0;
            db_level_q    <= 1'b1;
            db_last_q     <= 1'b1;
            step_req_q    <= 1'b0;
            state_q       <= StIdle;
            div_q         <= '0;
            bp_hit_q      <= '0;
            cycle_count_q <= '0;
            hex_q         <= {NUM_DIGITS{SegZero}};
        end else begin
            sync1_q       <= step_btn_n;
            sync2_q       <= sync1_q;
            db_cnt_q      <= db_cnt_d;
            db_level_q    <= db_level_d;
            db_last_q     <= db_level_q;
            step_req_q    <= step_req_d;
            state_q       <= state_d;
            div_q         <= div_d;
            bp_hit_q      <= bp_hit_d;
            cycle_count_q <= cycle_count_d;
            hex_q         <= hex_d;
        end
    end

    assign core_clk_en = core_en;
    assign halted      = (state_q != StRun);
    assign bp_hit      = bp_hit_q;
    assign cycle_count = cycle_count_q;
    assign hex_out     = hex_q;

endmodule
